bin_to_bcd_seq: RTL
===================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameters: none; input width fixed at 16 bits, output fixed at 5 BCD digits.
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  conversion request, sampled on rising edge of clock.
REQ-005 bin_in  input  16  unsigned binary value to convert, sampled with start.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking a new bcd_out value.
REQ-008 bcd_out  output  20  result, 5 packed BCD digits, [19:16] = ten-thousands and [3:0] = units.
REQ-009 digit_blank  output  5  per-digit leading-zero blank mask, bit i corresponds to digit i.

Function
REQ-010 The block SHALL feed the display multiplexer's 16-bit number input and SHALL convert binary to BCD iteratively using shift-add-3 (double dabble).
REQ-011 The FSM SHALL have states IDLE, CONVERT, DONE.
REQ-012 IDLE: start=1 at an edge SHALL latch bin_in, clear the 20-bit scratch BCD register and the 5-bit iteration counter, and move to CONVERT.
REQ-013 CONVERT: each cycle SHALL add 3 to every scratch nibble >= 5, then shift the {scratch, binary} register left 1 bit, with the binary MSB entering the scratch LSB.
REQ-014 The counter SHALL increment once per CONVERT cycle; after the 16th shift the FSM SHALL enter DONE.
REQ-015 DONE: bcd_out SHALL load the scratch value, done SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-016 busy SHALL be 1 in CONVERT only (exactly 16 cycles per conversion) and 0 in IDLE and DONE.
REQ-017 Latency: done SHALL be high in the cycle beginning 17 edges after the edge that sampled start.
REQ-018 bcd_out SHALL hold its previous value during CONVERT and change only on entry to DONE.
REQ-019 start asserted in CONVERT or DONE SHALL be ignored; it is not queued.
REQ-020 Holding start high SHALL cause back-to-back conversions, one every 18 cycles.
REQ-021 Changes on bin_in after the sampling edge SHALL NOT affect the result in progress.
REQ-022 All 16-bit inputs 0..65535 SHALL convert exactly; 65535 -> 20'h65535.
REQ-023 No BCD nibble of bcd_out SHALL exceed 9.

Reset
REQ-024 reset=1 SHALL immediately, independent of clock, force: state IDLE, busy 0, done 0, bcd_out 0, counter 0, scratch 0.
REQ-025 reset=1 SHALL set digit_blank to its reset value as defined in REQ-027 and REQ-029.
REQ-026 reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after reset release SHALL convert normally.

Configuration
REQ-027 Macro BIN_TO_BCD_BLANK_EN defined: digit_blank[i] for i=4..1 SHALL be 1 when digit i and all higher digits of bcd_out are 0.
REQ-028 With BIN_TO_BCD_BLANK_EN defined: digit_blank[0] SHALL always be 0, digit_blank SHALL update in the same cycle as bcd_out, and its reset value SHALL be 5'b11110.
REQ-029 Macro BIN_TO_BCD_BLANK_EN undefined: digit_blank SHALL be constant 5'b00000, including during reset; all other behaviour is unchanged.

Verification
REQ-030 Reset, then start with bin_in=0 -> done at +17 edges, bcd_out=20'h00000, digit_blank=5'b11110 (BLANK_EN) / 5'b00000 (otherwise).
REQ-031 bin_in=65535, start pulse -> busy high 16 cycles, bcd_out=20'h65535, done high exactly 1 cycle, digit_blank=5'b00000.
REQ-032 bin_in=1234, then bin_in changed to 9999 two cycles after start -> bcd_out=20'h01234, digit_blank=5'b10000 (BLANK_EN).
REQ-033 start pulsed again 5 cycles into a conversion of 40 -> single done, bcd_out=20'h00040, no second conversion.
REQ-034 reset asserted 8 cycles into a conversion of 500 -> outputs zero immediately, no done; after release, start with 500 -> bcd_out=20'h00500.
REQ-035 start held high with bin_in incrementing by 8 per conversion -> done every 18 cycles, each bcd_out equal to the BCD of the sampled value.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double dabble).
// One shift-add-3 iteration per clock; a conversion takes 16 CONVERT cycles,
// one DONE cycle, and the result appears together with a one-cycle done pulse.
// Optional feature macro: BIN_TO_BCD_BLANK_EN enables the leading-zero blank
// mask on digit_blank; without it digit_blank is tied to zero.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; bin_in is latched on the accepting edge
// ST_CONVERT | 16 shift-add-3 iterations, busy high
// ST_DONE    | scratch holds the final BCD; bcd_out/done update on exit
module bin_to_bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_out,
  output logic [4:0]  digit_blank
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]  state;
  logic [15:0] bin_sr;
  logic [19:0] scratch;
  logic [4:0]  count;
  logic [19:0] adjusted;
  logic [19:0] shifted;
  logic        done_q;
  logic [19:0] bcd_q;

  // Add-3 correction on every scratch nibble that would overflow a decimal
  // digit after the next doubling.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[18:0], bin_sr[15]};
  end

  // Control FSM, iteration counter, shift registers and the result register.
  // bcd_out and done are registered on leaving DONE so the result lands 17
  // edges after the sampling edge and a held start repeats every 18 cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bin_sr  <= 16'd0;
      scratch <= 20'd0;
      count   <= 5'd0;
      done_q  <= 1'b0;
      bcd_q   <= 20'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= 20'd0;
            count   <= 5'd0;
            state   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          scratch <= shifted;
          bin_sr  <= {bin_sr[14:0], 1'b0};
          count   <= count + 5'd1;
          if (count == 5'd15) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_q  <= scratch;
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state == ST_CONVERT);
  assign done    = done_q;
  assign bcd_out = bcd_q;

`ifdef BIN_TO_BCD_BLANK_EN
  logic [4:0] blank_next;
  logic [4:0] blank_q;

  // A digit blanks when it and every more significant digit are zero; the
  // units digit is never blanked so a zero result still shows "0".
  always_comb begin
    blank_next    = 5'b00000;
    blank_next[4] = (scratch[19:16] == 4'd0);
    blank_next[3] = blank_next[4] && (scratch[15:12] == 4'd0);
    blank_next[2] = blank_next[3] && (scratch[11:8]  == 4'd0);
    blank_next[1] = blank_next[2] && (scratch[7:4]   == 4'd0);
  end

  // Blank mask is loaded on the same edge as bcd_out; reset matches a zero result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blank_q <= 5'b11110;
    end else if (state == ST_DONE) begin
      blank_q <= blank_next;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 5'b00000;
`endif

endmodule
